// File: rtl/complex_counter_n.sv
// -----------------------------------------------------------------------------
// complex_counter_n
//
// Up/down counter whose output is either plain binary or reflected Gray code.
// Internally a single binary index (r_idx) is the only sequence state; the
// output code is derived from it, so switching Mode never disturbs the
// position in the sequence. All state updates on the FALLING edge of Clk.
//
// Ports:
//   Clk      in   clock, falling-edge active
//   nReset   in   asynchronous active-low reset (clears index, Count, Tc)
//   Mode     in   0 = binary code, 1 = reflected Gray code
//   En       in   step one position per falling edge when high
//   Up       in   1 = forward, 0 = backward through the sequence
//   Load     in   synchronous load strobe (priority over En)
//   LoadVal  in   load value, interpreted in the code selected by Mode
//   Count    out  registered count, encoded per Mode
//   Tc       out  registered one-cycle pulse after an enabled wrap
// -----------------------------------------------------------------------------
module complex_counter_n #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Mode,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Count,
    output logic             Tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_idx;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    logic [WIDTH-1:0] w_idx_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap;

    // Binary -> reflected Gray.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray -> binary: bit i is the XOR of all Gray bits at and above i,
    // which is the XOR of every right-shifted copy of the input.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Next index: Load beats En beats hold. Only an enabled step can wrap,
    // so a load landing on a boundary value never raises Tc.
    always_comb begin
        w_idx_nxt = r_idx;
        w_wrap    = 1'b0;
        if (Load) begin
            w_idx_nxt = Mode ? gray_to_bin(LoadVal) : LoadVal;
        end else if (En) begin
            if (Up) begin
                w_idx_nxt = r_idx + ONE;
                w_wrap    = (r_idx == '1);
            end else begin
                w_idx_nxt = r_idx - ONE;
                w_wrap    = (r_idx == '0);
            end
        end
    end

    // Output encoding uses the Mode sampled on the same edge as the index
    // update, so a Mode change re-encodes the held index one edge later.
    always_comb begin
        w_count_nxt = Mode ? bin_to_gray(w_idx_nxt) : w_idx_nxt;
    end

    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_idx   <= '0;
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_wrap;
        end
    end

    assign Count = r_count;
    assign Tc    = r_tc;

endmodule

// File: doc/complex_counter_n.md
COMPLEX_COUNTER_N -- requirements
Module: complex_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, counter width in bits (legal range 2..16).
REQ-002 The block SHALL have port Clk  input  1  clock; all state updates occur on the falling edge of Clk.
REQ-003 The block SHALL have port nReset  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port Mode  input  1  code select: 0 = binary sequence, 1 = reflected Gray sequence.
REQ-005 The block SHALL have port En  input  1  count enable: step one position per falling edge when high.
REQ-006 The block SHALL have port Up  input  1  direction: 1 = forward through the sequence, 0 = backward.
REQ-007 The block SHALL have port Load  input  1  synchronous load strobe.
REQ-008 The block SHALL have port LoadVal  input  WIDTH  load value, interpreted in the code selected by Mode.
REQ-009 The block SHALL have port Count  output  WIDTH  registered count, encoded per Mode.
REQ-010 The block SHALL have port Tc  output  1  registered one-cycle terminal-count (wrap) pulse.

Function
REQ-011 The block SHALL hold a WIDTH-bit binary sequence index Idx as its only sequence state; Count SHALL be encode(Idx, Mode), registered.
REQ-012 encode SHALL be: Mode=0 -> Idx; Mode=1 -> Idx ^ (Idx >> 1).
REQ-013 Per falling edge, next Idx priority SHALL be: Load, then En, then hold.
REQ-014 On Load=1, Idx SHALL become LoadVal when Mode=0, or Gray-to-binary(LoadVal) when Mode=1 (bit i = XOR of LoadVal bits WIDTH-1..i); En and Up are ignored on that edge.
REQ-015 On Load=0, En=1, Up=1, Idx SHALL become Idx+1 modulo 2^WIDTH.
REQ-016 On Load=0, En=1, Up=0, Idx SHALL become Idx-1 modulo 2^WIDTH.
REQ-017 On Load=0, En=0, Idx SHALL hold.
REQ-018 Count SHALL be updated every falling edge from the next Idx and the Mode sampled on that edge, so a Mode change with En=0 re-encodes the held index one edge later without altering Idx.
REQ-019 A Mode change SHALL NOT reset or reinterpret Idx; the sequence continues from the same index position in the new code.
REQ-020 In Gray mode, consecutive Count values under En=1 SHALL differ in exactly one bit, including across wrap.
REQ-021 Tc SHALL be 1 for exactly the cycle following an edge where En=1, Load=0, and Idx wrapped (Up=1 from 2^WIDTH-1 to 0, or Up=0 from 0 to 2^WIDTH-1); otherwise 0.
REQ-022 Load SHALL never assert Tc, even if LoadVal equals a wrap boundary.
REQ-023 Latency from an input change to Count/Tc SHALL be exactly one falling edge; no output path is combinational from inputs.
REQ-024 Changing Up on any edge SHALL take effect on that edge with no extra step or skipped value.

Reset
REQ-025 While nReset=0, Idx, Count and Tc SHALL be 0 immediately, independent of Clk.
REQ-026 Reset asserted mid-count SHALL discard any pending step or load; the first enabled falling edge after nReset rises SHALL produce Count=encode(1,Mode) for Up=1 or encode(2^WIDTH-1,Mode) for Up=0.
REQ-027 nReset deassertion SHALL take effect at the next falling edge; no output changes on the deassertion itself.

Verification
REQ-028 WIDTH=3, Mode=0, Up=1, En=1 for 9 edges -> Count 1,2,3,4,5,6,7,0,1; Tc=1 only in the cycle Count=0.
REQ-029 WIDTH=3, Mode=1, Up=1, En=1 for 8 edges -> Count 001,011,010,110,111,101,100,000; every step one-bit change; Tc=1 with 000.
REQ-030 WIDTH=3, Mode=1, Up=0, En=1 from reset -> Count 100,101,111,110; Tc=1 only with the first 100.
REQ-031 WIDTH=3, Mode=1, Load=1, LoadVal=110, En=1 -> Count=110, Idx=4, Tc=0; then Mode=0, En=0 -> Count=100 after one edge, Idx unchanged.
REQ-032 WIDTH=4, Mode=0, Count=9, nReset pulsed low between edges -> Count=0 and Tc=0 immediately; next En=1 edge -> Count=1.
REQ-033 WIDTH=3, Mode=0, Count=7, Load=1, LoadVal=0, En=1, Up=1 -> Count=0, Tc=0 (load wins, no wrap pulse).
